// File: rtl/router_pkg.sv
// router_pkg: shared constants and the FIFO entry type for the router output buffers.
package router_pkg;
    localparam int DW = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int PKT_CNT_W = 7;
    typedef struct packed {
        logic          hdr;
        logic [DW-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/router_fifo_ram.sv
// router_fifo_ram: DEPTH x (DW+1) register array, sync write, async read.
// Only the header flags are reset; payload bytes are never readable before being written.
module router_fifo_ram
    import router_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [AW-1:0] raddr_i,
    input  fifo_entry_t   wdata_i,
    output fifo_entry_t   rdata_o
);
    logic [DEPTH-1:0] hdr_q;
    logic [DW-1:0]    data_q [DEPTH];

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) hdr_q <= '0;
        else if (clr_i) hdr_q <= '0;
        else if (we_i) hdr_q[waddr_i] <= wdata_i.hdr;

    always_ff @(posedge clock)
        if (we_i) data_q[waddr_i] <= wdata_i.data;

    assign rdata_o = '{hdr: hdr_q[raddr_i], data: data_q[raddr_i]};
endmodule

// File: rtl/router_fifo.sv
// router_fifo: one router output buffer storing {header flag, byte} entries.
// Tracks bytes remaining in the packet being read, loaded from the header's length field.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 soft_reset,
    input  logic                 write_enb,
    input  logic                 read_enb,
    input  logic                 lfd_state,
    input  logic [DW-1:0]        data_in,
    output logic [DW-1:0]        data_out,
    output logic                 full,
    output logic                 empty,
    output logic [PKT_CNT_W-1:0] pkt_cnt
);
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic [DW-1:0]        dout_q, dout_d;
    logic [PKT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 lfd_q, lfd_d;
    logic                 do_wr, do_rd;
    fifo_entry_t          rdata;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_wr = write_enb && !full && !soft_reset;
    assign do_rd = read_enb && !empty && !soft_reset;

    router_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clock   (clock),
        .resetn  (resetn),
        .clr_i   (soft_reset),
        .we_i    (do_wr),
        .waddr_i (wr_q[AW-1:0]),
        .raddr_i (rd_q[AW-1:0]),
        .wdata_i ('{hdr: lfd_q, data: data_in}),
        .rdata_o (rdata)
    );

    // Header length field counts payload only; +1 covers the trailing parity byte.
    always_comb begin
        wr_d   = soft_reset ? '0 : do_wr ? wr_q + (AW+1)'(1) : wr_q;
        rd_d   = soft_reset ? '0 : do_rd ? rd_q + (AW+1)'(1) : rd_q;
        dout_d = soft_reset ? '0 : do_rd ? rdata.data : dout_q;
        lfd_d  = soft_reset ? 1'b0 : lfd_state;
        cnt_d  = cnt_q;
        if (soft_reset) cnt_d = '0;
        else if (do_rd) cnt_d = rdata.hdr ? PKT_CNT_W'(rdata.data[DW-1:2]) + PKT_CNT_W'(1)
                              : (cnt_q != '0) ? cnt_q - PKT_CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            dout_q <= '0;
            cnt_q  <= '0;
            lfd_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
            lfd_q  <= lfd_d;
        end

    assign data_out = dout_q;
    assign pkt_cnt  = cnt_q;
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed tests for router_fifo against a queue-based reference model.
module tb_router_fifo;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       full, empty;
    logic [6:0] pkt_cnt;

    int checks = 0;
    int failures = 0;

    logic [8:0] q[$];
    logic [7:0] m_dout = '0;
    int         m_cnt = 0;
    logic       m_lfd = 1'b0;

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: occupancy is just the queue length; flags come from it.
    always @(posedge clock or negedge resetn) begin
        if (!resetn || soft_reset) begin
            q.delete();
            m_dout = '0;
            m_cnt = 0;
            m_lfd = 1'b0;
        end else begin
            logic [8:0] ent;
            bit f, e;
            f = (q.size() == 16);
            e = (q.size() == 0);
            if (read_enb && !e) begin
                ent = q.pop_front();
                m_dout = ent[7:0];
                if (ent[8]) m_cnt = int'(ent[7:2]) + 1;
                else if (m_cnt != 0) m_cnt = m_cnt - 1;
            end
            if (write_enb && !f) q.push_back({m_lfd, data_in});
            m_lfd = lfd_state;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("model_empty", 32'(empty), 32'(q.size() == 0));
        chk("model_full", 32'(full), 32'(q.size() == 16));
        chk("model_dout", 32'(data_out), 32'(m_dout));
        chk("model_cnt", 32'(pkt_cnt), 32'(m_cnt));
    end

    task automatic cyc(input logic w, input logic r, input logic l, input logic [7:0] d);
        write_enb = w;
        read_enb = r;
        lfd_state = l;
        data_in = d;
        @(negedge clock);
        write_enb = 1'b0;
        read_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        resetn = 1'b1;
        // T1: async reset mid-write
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'hAA + 8'(i));
        cyc(0, 1, 0, 8'h00);
        chk("t1_pre_dout", 32'(data_out), 32'hAA);
        write_enb = 1'b1;
        data_in = 8'hDD;
        #3 resetn = 1'b0;
        #1;
        chk("t1_empty", 32'(empty), 1);
        chk("t1_full", 32'(full), 0);
        chk("t1_dout", 32'(data_out), 0);
        @(negedge clock);
        write_enb = 1'b0;
        resetn = 1'b1;
        // T2: fill, overflow, drain
        for (int i = 1; i <= 16; i++) cyc(1, 0, 0, 8'(i));
        chk("t2_full", 32'(full), 1);
        cyc(1, 0, 0, 8'h99);
        chk("t2_full_drop", 32'(full), 1);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 0, 8'h00);
            chk("t2_dout", 32'(data_out), 32'(i));
        end
        chk("t2_empty", 32'(empty), 1);
        // T3: header-driven packet count
        cyc(0, 0, 1, 8'h00);
        cyc(1, 0, 0, 8'h14);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'h50 + 8'(i));
        cyc(0, 1, 0, 8'h00);
        chk("t3_hdr_dout", 32'(data_out), 32'h14);
        chk("t3_cnt_load", 32'(pkt_cnt), 6);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 8'h00);
            chk("t3_cnt_dec", 32'(pkt_cnt), 32'(5 - i));
        end
        chk("t3_empty", 32'(empty), 1);
        // T4: simultaneous access at full and at empty
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'h20 + 8'(i));
        chk("t4_full", 32'(full), 1);
        cyc(1, 1, 0, 8'hEE);
        chk("t4_rd_dout", 32'(data_out), 32'h20);
        chk("t4_full_clr", 32'(full), 0);
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 8'h00);
        chk("t4_drain_dout", 32'(data_out), 32'h2F);
        chk("t4_drained", 32'(empty), 1);
        cyc(1, 1, 0, 8'h77);
        chk("t4_empty_wr", 32'(empty), 0);
        chk("t4_dout_hold", 32'(data_out), 32'h2F);
        cyc(0, 1, 0, 8'h00);
        chk("t4_late_rd", 32'(data_out), 32'h77);
        // T5: soft reset overrides a read with 5 entries held
        cyc(0, 0, 1, 8'h00);
        cyc(1, 0, 0, 8'h0C);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'h60 + 8'(i));
        cyc(0, 1, 0, 8'h00);
        chk("t5_cnt", 32'(pkt_cnt), 4);
        soft_reset = 1'b1;
        cyc(0, 1, 0, 8'h00);
        soft_reset = 1'b0;
        chk("t5_empty", 32'(empty), 1);
        chk("t5_cnt_clr", 32'(pkt_cnt), 0);
        chk("t5_dout_clr", 32'(data_out), 0);
        // T6: steady write/read pairs across pointer wrap
        cyc(1, 0, 0, 8'h80);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 8'h81 + 8'(i));
            chk("t6_dout", 32'(data_out), 32'(8'h80 + 8'(i)));
            chk("t6_not_empty", 32'(empty), 0);
            chk("t6_not_full", 32'(full), 0);
        end
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
